// File: rtl/axis_stream_fifo_if.sv
// axis_stream_fifo_if: one valid/ready stream leg carrying data plus an end-of-packet flag.
// master drives valid/data/last and samples ready; slave is the mirror image.
interface axis_stream_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axis_stream_fifo.sv
// axis_stream_fifo: synchronous first-word-fall-through stream FIFO with fill level,
// almost-full/almost-empty flags and an optional store-and-forward packet mode.
// Define AXIS_STREAM_FIFO_PKT_MODE_EN to hold words back until a whole packet is stored.
// Without it the FIFO is plain cut-through and pkt_cnt reads 0.
module axis_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter     RAM_STYLE  = "distributed",
    parameter int AF_TH      = 1,
    parameter int AE_TH      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    axis_stream_fifo_if.slave   wr,
    axis_stream_fifo_if.master  rd,
    output logic [ADDR_WIDTH:0] level,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDR_WIDTH:0] pkt_cnt
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;
    // Thresholds pre-converted to level width so the flag compares stay width-matched.
    localparam logic [ADDR_WIDTH:0] AF_LVL = LW'(DEPTH - AF_TH);
    localparam logic [ADDR_WIDTH:0] AE_LVL = LW'(AE_TH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic [ADDR_WIDTH:0] level_q;
    logic [DATA_WIDTH:0] rd_word;   // {last, data} at the read pointer
    logic                empty;
    logic                full;
    logic                wr_fire;
    logic                rd_fire;
    logic                rd_avail;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                     (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    // A full FIFO never takes a write, even if a read frees a slot this cycle.
    assign wr_fire = wr.valid & ~full;
    assign rd_fire = rd_avail & rd.ready;

    // Storage is unreset; only written slots are ever presented on rd.data.
    generate
        if (RAM_STYLE == "block") begin : g_bram
            (* ram_style = "block" *) logic [DATA_WIDTH:0] mem [DEPTH];

            // Write port: store {last, data} at the write pointer.
            always_ff @(posedge clk) begin
                if (wr_fire) mem[wptr[ADDR_WIDTH-1:0]] <= {wr.last, wr.data};
            end

            assign rd_word = mem[rptr[ADDR_WIDTH-1:0]];
        end else begin : g_dram
            (* ram_style = "distributed" *) logic [DATA_WIDTH:0] mem [DEPTH];

            // Write port: store {last, data} at the write pointer.
            always_ff @(posedge clk) begin
                if (wr_fire) mem[wptr[ADDR_WIDTH-1:0]] <= {wr.last, wr.data};
            end

            assign rd_word = mem[rptr[ADDR_WIDTH-1:0]];
        end
    endgenerate

    // Pointer advance on accepted transfers; binary wrap at 2*DEPTH comes for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_fire) wptr <= wptr + 1'b1;
            if (rd_fire) rptr <= rptr + 1'b1;
        end
    end

    // Registered fill level; a simultaneous write and read cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            unique case ({wr_fire, rd_fire})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef AXIS_STREAM_FIFO_PKT_MODE_EN
    logic [ADDR_WIDTH:0] pkt_q;
    logic                pkt_in;
    logic                pkt_out;

    assign pkt_in  = wr_fire & wr.last;
    assign pkt_out = rd_fire & rd_word[DATA_WIDTH];

    // Count of complete packets held; a packet entering and one leaving cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q <= '0;
        end else begin
            unique case ({pkt_in, pkt_out})
                2'b10:   pkt_q <= pkt_q + 1'b1;
                2'b01:   pkt_q <= pkt_q - 1'b1;
                default: pkt_q <= pkt_q;
            endcase
        end
    end

    // Release words only once a whole packet is inside. A packet larger than the
    // FIFO would never complete, so a full FIFO lets that packet trickle out.
    assign rd_avail = ~empty & ((pkt_q != '0) | full);
    assign pkt_cnt  = pkt_q;
`else
    assign rd_avail = ~empty;
    assign pkt_cnt  = '0;
`endif

    // Read side: FWFT, data forced to zero whenever nothing is offered.
    always_comb begin
        rd.valid = rd_avail;
        rd.data  = rd_avail ? rd_word[DATA_WIDTH-1:0] : '0;
        rd.last  = rd_avail & rd_word[DATA_WIDTH];
    end

    // Status outputs, all derived from registered state.
    always_comb begin
        wr.ready     = ~full;
        level        = level_q;
        almost_full  = (level_q >= AF_LVL);
        almost_empty = (level_q <= AE_LVL);
    end
endmodule
